// File: rtl/div_if.sv
// Operand/result and stall handshake between the EX stage and div_unit.
// DIV_ZERO_FLAG_EN adds the div_zero_o divide-by-zero indication.
interface div_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  start_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stall_o;
`ifdef DIV_ZERO_FLAG_EN
  logic                  div_zero_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_o, div_zero_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_o, div_zero_o
  );
`else
  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_o
  );
`endif
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Optional DIV_ZERO_FLAG_EN drives div_zero_o in the END cycle after a divide by zero.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam int unsigned WRK_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_e;

  state_e                state_q, state_d;
  logic [WRK_W-1:0]      work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  quot_neg_q, quot_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  div_zero_q, div_zero_d;

  logic                  accept;
  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     op1_mag, op2_mag;
  logic [WRK_W-1:0]      shifted, step_work;
  logic [DATA_W:0]       trial;
  logic [DATA_W-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;

  assign accept  = bus.start_i && !bus.annul_i;
  assign op1_neg = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i && bus.opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? DATA_W'(-bus.opdata1_i) : bus.opdata1_i;
  assign op2_mag = op2_neg ? DATA_W'(-bus.opdata2_i) : bus.opdata2_i;

  // One shift-subtract step; the upper part always stays below the divisor.
  assign shifted   = work_q << 1;
  assign trial     = shifted[WRK_W-1:DATA_W] - {1'b0, divisor_q};
  assign step_work = trial[DATA_W] ? shifted : {trial, shifted[DATA_W-1:1], 1'b1};
  assign quot_raw  = step_work[DATA_W-1:0];
  assign rem_raw   = step_work[2*DATA_W-1:DATA_W];
  assign quot_fix  = quot_neg_q ? DATA_W'(-quot_raw) : quot_raw;
  assign rem_fix   = rem_neg_q  ? DATA_W'(-rem_raw)  : rem_raw;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    ready_d    = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          work_d     = {(DATA_W + 1)'(0), op1_mag};
          divisor_d  = op2_mag;
          quot_neg_d = op1_neg ^ op2_neg;
          rem_neg_d  = op1_neg;
          cnt_d      = '0;
          state_d    = (bus.opdata2_i == '0) ? ZERO : ON;
        end
      end
      ZERO: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          result_d   = '0;
          ready_d    = 1'b1;
          div_zero_d = 1'b1;
          state_d    = END;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            result_d = {rem_fix, quot_fix};
            ready_d  = 1'b1;
            state_d  = END;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Stall drops in END so the pipeline advances on the HI/LO commit edge.
  assign bus.stall_o  = (state_q == IDLE && accept) || state_q == ZERO || state_q == ON;
  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

`ifdef DIV_ZERO_FLAG_EN
  assign bus.div_zero_o = div_zero_q;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide by zero, annul, reset abort and back-to-back operation.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rdy_cnt;

  always #5 clk = ~clk;

  div_if #(.DATA_W(32)) dif();

  div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a divide in the current cycle (cycle 0) and returns in the cycle after ready_o.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int          lat;
    logic        stall_bad;
    logic        stall_end;
    logic        dz_end;
    logic        dz_bad;
    logic [63:0] res;
    lat = -1; stall_bad = 1'b0; stall_end = 1'b1; dz_end = 1'b0; dz_bad = 1'b0; res = '0;
    dif.start_i      = 1'b1;
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dif.ready_o === 1'b1) begin
        lat       = c;
        res       = dif.result_o;
        stall_end = dif.stall_o;
`ifdef DIV_ZERO_FLAG_EN
        dz_end    = dif.div_zero_o;
`endif
      end else begin
        if (dif.stall_o !== 1'b1) stall_bad = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
        if (dif.div_zero_o !== 1'b0) dz_bad = 1'b1;
`endif
      end
      tick();
      dif.start_i = 1'b0;
      if (lat >= 0) break;
    end
    chk({tag, "_latency"},    64'(lat), 64'(exp_lat));
    chk({tag, "_result"},     res, exp_res);
    chk({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    chk({tag, "_stall_end"},  64'(stall_end), 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, "_div_zero_end"},   64'(dz_end), 64'(b == 32'd0));
    chk({tag, "_div_zero_other"}, 64'(dz_bad), 64'd0);
`else
    chk({tag, "_div_zero_end"},   64'(dz_end | dz_bad), 64'd0);
`endif
  endtask

  initial begin
    rst              = 1'b1;
    dif.start_i      = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.annul_i      = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_result", dif.result_o, 64'd0);
    chk("reset_ready",  64'(dif.ready_o), 64'd0);
    chk("reset_stall",  64'(dif.stall_o), 64'd0);
    tick();
    rst = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    @(negedge clk);
    chk("idle_after_end_ready", 64'(dif.ready_o), 64'd0);
    chk("idle_after_end_stall", 64'(dif.stall_o), 64'd0);
    tick();

    do_div("div_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,        33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("div_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
    do_div("divu_ovf",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'h0000_0000});

    // Annul in cycle 10 of a 100/7 divide, fresh 9/3 start in cycle 12
    dif.start_i      = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    tick();
    dif.start_i = 1'b0;
    repeat (9) tick();
    dif.annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall_on", 64'(dif.stall_o), 64'd1);
    tick();
    dif.annul_i = 1'b0;
    @(negedge clk);
    chk("annul_ready",       64'(dif.ready_o), 64'd0);
    chk("annul_stall_idle",  64'(dif.stall_o), 64'd0);
    chk("annul_result_held", dif.result_o, {32'h8000_0000, 32'h0000_0000});
    tick();
    do_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 64'd0);

    do_div("b2b_6_4", 1'b0, 32'd6, 32'd4, 33, {32'd2, 32'd1});
    do_div("b2b_8_3", 1'b0, 32'd8, 32'd3, 33, {32'd2, 32'd2});

    // Reset in cycle 5 of a divide
    dif.start_i   = 1'b1;
    dif.opdata1_i = 32'd100;
    dif.opdata2_i = 32'd7;
    tick();
    dif.start_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_result", dif.result_o, 64'd0);
    chk("rst_mid_ready",  64'(dif.ready_o), 64'd0);
    chk("rst_mid_stall",  64'(dif.stall_o), 64'd0);
    rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk);
      if (dif.ready_o === 1'b1) rdy_cnt++;
    end
    chk("rst_mid_no_ready", 64'(rdy_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
